// File: rtl/sisa_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sisa_pkg                                                     |
// | Description : Shared sISA constants: loader framing, instruction memory    |
// |               geometry, loader state encoding and core opcodes.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package sisa_pkg;

    localparam logic [7:0] c_SYNC_DEFAULT = 8'hA5;
    localparam int         c_IMEM_DEPTH   = 16;
    localparam int         c_IMEM_ADDR_W  = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_RUN  = 3'd4
    } load_state_e;

    // Core opcodes occupy the upper nibble of each instruction byte.
    localparam logic [3:0] c_OP_NOP = 4'h0;
    localparam logic [3:0] c_OP_LDI = 4'h8;
    localparam logic [3:0] c_OP_MOV = 4'h9;
    localparam logic [3:0] c_OP_ADD = 4'hA;
    localparam logic [3:0] c_OP_SUB = 4'hB;
    localparam logic [3:0] c_OP_BNZ = 4'hC;
    localparam logic [3:0] c_OP_JMP = 4'hD;

endpackage
`default_nettype wire

// File: rtl/sisa_prog_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sisa_prog_loader                                             |
// | Description : Framed byte-stream loader for the sISA instruction memory;   |
// |               holds the core in reset until a frame passes its checksum.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sisa_prog_loader
    import sisa_pkg::*;
#(
    parameter logic [7:0] SYNC  = c_SYNC_DEFAULT,
    parameter int         DEPTH = c_IMEM_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [7:0]                 in_data,
    output logic                       in_ready,
    output logic                       mem_we,
    output logic [$clog2(DEPTH)-1:0]   mem_addr,
    output logic [7:0]                 mem_wdata,
    output logic                       cpu_rst,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int         c_ADDR_W  = $clog2(DEPTH);
    localparam int         c_LEN_W   = c_ADDR_W + 1;
    localparam logic [7:0] c_DEPTH_B = 8'(DEPTH);

    load_state_e           r_state, w_state_nxt;
    logic [7:0]            r_sum,   w_sum_nxt;
    logic [c_LEN_W-1:0]    r_len,   w_len_nxt;
    logic [c_ADDR_W-1:0]   r_idx,   w_idx_nxt;
    logic                  r_we,    w_we_nxt;
    logic [c_ADDR_W-1:0]   r_addr,  w_addr_nxt;
    logic [7:0]            r_wdata, w_wdata_nxt;
    logic                  r_err,   w_err_nxt;

    logic                  w_hs;
    logic [7:0]            w_sum_add;
    logic [c_LEN_W-1:0]    w_idx_inc;

    assign w_hs      = in_valid & in_ready;
    assign w_sum_add = r_sum + in_data;
    assign w_idx_inc = {1'b0, r_idx} + c_LEN_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sum   <= '0;
            r_len   <= '0;
            r_idx   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sum   <= w_sum_nxt;
            r_len   <= w_len_nxt;
            r_idx   <= w_idx_nxt;
            r_we    <= w_we_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sum_nxt   = r_sum;
        w_len_nxt   = r_len;
        w_idx_nxt   = r_idx;
        w_we_nxt    = 1'b0;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_err_nxt   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_hs && in_data == SYNC) begin
                    w_state_nxt = ST_LEN;
                end
            end
            ST_LEN: begin
                if (w_hs) begin
                    if (in_data == 8'd0 || in_data > c_DEPTH_B) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_len_nxt   = in_data[c_LEN_W-1:0];
                        w_sum_nxt   = in_data;
                        w_idx_nxt   = '0;
                        w_state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                // SYNC is ordinary payload here; only the byte count ends DATA.
                if (w_hs) begin
                    w_we_nxt    = 1'b1;
                    w_addr_nxt  = r_idx;
                    w_wdata_nxt = in_data;
                    w_sum_nxt   = w_sum_add;
                    w_idx_nxt   = r_idx + c_ADDR_W'(1);
                    if (w_idx_inc == r_len) begin
                        w_state_nxt = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (w_hs) begin
                    if (w_sum_add == 8'd0) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_RUN: begin
                if (w_hs && in_data == SYNC) begin
                    w_state_nxt = ST_LEN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign in_ready  = 1'b1;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign err       = r_err;
    assign cpu_rst   = (r_state != ST_RUN);
    assign done      = (r_state == ST_RUN);
    assign busy      = (r_state == ST_LEN) || (r_state == ST_DATA) || (r_state == ST_CSUM);

endmodule
`default_nettype wire

// File: tb/tb_sisa_prog_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sisa_prog_loader                                          |
// | Description : Randomized self-checking bench for sisa_prog_loader against  |
// |               a frame-buffer reference model.                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sisa_prog_loader;

    localparam logic [7:0] c_SYNC = 8'hA5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_rst;
    logic       busy;
    logic       done;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: bytes collected since SYNC, plus a "program running" flag.
    bit          m_in_frame = 1'b0;
    bit          m_running  = 1'b0;
    int unsigned m_frame[$];
    logic [7:0]  m_mem[16];
    logic [7:0]  shadow_mem[16];

    logic       e_we;
    logic [3:0] e_addr;
    logic [7:0] e_data;
    logic       e_err;

    sisa_prog_loader #(.SYNC(c_SYNC), .DEPTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        int unsigned n;
        int unsigned s;
        if (!m_in_frame) begin
            if (b == c_SYNC) begin
                m_in_frame = 1'b1;
                m_running  = 1'b0;
                m_frame.delete();
            end
        end else begin
            m_frame.push_back(int'(b));
            n = m_frame[0];
            if (m_frame.size() == 1) begin
                if (n == 0 || n > 16) begin
                    e_err      = 1'b1;
                    m_in_frame = 1'b0;
                end
            end else if (m_frame.size() <= n + 1) begin
                e_we   = 1'b1;
                e_addr = 4'(m_frame.size() - 2);
                e_data = b;
                m_mem[e_addr] = b;
            end else begin
                s = 0;
                foreach (m_frame[i]) s += m_frame[i];
                if (s % 256 == 0) m_running = 1'b1;
                else e_err = 1'b1;
                m_in_frame = 1'b0;
            end
        end
    endtask

    task automatic check_outputs();
        check_val("in_ready", in_ready, 1);
        check_val("busy", busy, m_in_frame);
        check_val("done", done, m_running);
        check_val("cpu_rst", cpu_rst, !m_running);
        check_val("err", err, e_err);
        check_val("mem_we", mem_we, e_we);
        if (e_we) begin
            check_val("mem_addr", mem_addr, e_addr);
            check_val("mem_wdata", mem_wdata, e_data);
        end
        if (mem_we) shadow_mem[mem_addr] = mem_wdata;
    endtask

    // Called at a negedge; presents one cycle of input and checks the result one cycle later.
    task automatic step(input logic v, input logic [7:0] b);
        in_valid = v;
        in_data  = b;
        @(posedge clk);
        e_we = 1'b0; e_err = 1'b0; e_addr = '0; e_data = '0;
        if (v) model_byte(b);
        @(negedge clk);
        in_valid = 1'b0;
        check_outputs();
    endtask

    task automatic send(input logic [7:0] b);
        if ($urandom_range(0, 4) == 0) step(1'b0, 8'($urandom));
        step(1'b1, b);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'($urandom);
        in_data  = c_SYNC;
        @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        m_in_frame = 1'b0;
        m_running  = 1'b0;
        m_frame.delete();
        check_val("rst_mem_we", mem_we, 0);
        check_val("rst_mem_addr", mem_addr, 0);
        check_val("rst_mem_wdata", mem_wdata, 0);
        check_val("rst_cpu_rst", cpu_rst, 1);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_err", err, 0);
    endtask

    // Sends SYNC, N, N bytes, checksum; optionally corrupts the checksum.
    task automatic send_frame(input int n, input bit bad_csum, input int rst_after);
        logic [7:0] sum;
        logic [7:0] d;
        send(c_SYNC);
        send(8'(n));
        if (n < 1 || n > 16) return;
        sum = 8'(n);
        for (int i = 0; i < n; i++) begin
            d = ($urandom_range(0, 7) == 0) ? c_SYNC : 8'($urandom);
            sum += d;
            send(d);
            if (i + 1 == rst_after) begin
                do_reset();
                return;
            end
        end
        d = 8'(0) - sum;
        if (bad_csum) d ^= 8'(1 << $urandom_range(0, 7));
        send(d);
    endtask

    task automatic send_list(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send(bytes[i]);
    endtask

    initial begin
        logic [7:0] frm[$];
        int n;
        for (int i = 0; i < 16; i++) begin
            m_mem[i]      = 8'h00;
            shadow_mem[i] = 8'h00;
        end
        @(negedge clk);
        do_reset();

        // Garbage, then the reference program.
        send_list('{8'h00, 8'hFF, 8'h12});
        frm = '{8'hA5, 8'h08, 8'h8A, 8'h90, 8'hA0, 8'hB1, 8'h17, 8'h29, 8'hD1, 8'hDF, 8'h9D};
        send_list(frm);
        check_val("valid_load_done", done, 1);

        // Same frame with a corrupted checksum.
        frm[10] = 8'h9E;
        send_list(frm);
        check_val("bad_csum_cpu_rst", cpu_rst, 1);

        // Length bounds.
        send_list('{8'hA5, 8'h00});
        send_list('{8'hA5, 8'h11});
        send_frame(16, 1'b0, 0);
        check_val("len16_done", done, 1);

        // Reload from RUN, then abort mid-frame and reload cleanly.
        send_list('{8'h33, 8'h44});
        send_frame(5, 1'b0, 0);
        send_frame(9, 1'b0, 3);
        send_frame(6, 1'b0, 0);
        check_val("post_abort_done", done, 1);

        for (int f = 0; f < 80; f++) begin
            repeat ($urandom_range(0, 3)) begin
                logic [7:0] g;
                g = 8'($urandom);
                if (g == c_SYNC) g = 8'h5A;
                send(g);
            end
            if ($urandom_range(0, 7) == 0)
                n = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(17, 255));
            else
                n = int'($urandom_range(1, 16));
            send_frame(n, $urandom_range(0, 3) == 0,
                       ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 16)) : 0);
        end
        repeat (3) step(1'b0, 8'h00);

        for (int i = 0; i < 16; i++) check_val("final_mem", shadow_mem[i], m_mem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
